// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and the control-state enumeration.
package muldiv_pkg;

   // Operation select; bit 1 set means a divide.
   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,  // low half of the product
      OP_UMULH = 2'b01,  // high half of the unsigned product
      OP_UDIV  = 2'b10,  // unsigned quotient
      OP_SDIV  = 2'b11   // signed quotient, truncated toward zero
   } op_e;

   // Control states of the sequencer.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing pipeline and the
// multiply/divide unit. The pipeline is the master.
interface muldiv_if #(
   parameter int BUS_BITS = 64
);
   import muldiv_pkg::*;

   logic                start;
   op_e                 op;
   logic [BUS_BITS-1:0] in1;
   logic [BUS_BITS-1:0] in2;
   logic                flush;
   logic                busy;
   logic                done;
   logic [BUS_BITS-1:0] result;

   modport master (
      output start, op, in1, in2, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, op, in1, in2, flush,
      output busy, done, result
   );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation. Used on entry to take the
// magnitude of a negative signed operand, and on exit to restore the
// quotient sign. Negating the most negative value wraps to itself.
module muldiv_sign_fix #(
   parameter int BUS_BITS = 64
) (
   input  logic [BUS_BITS-1:0] i_value,
   input  logic                i_negate,
   output logic [BUS_BITS-1:0] o_value
);

   assign o_value = i_negate ? -i_value : i_value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. One shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle, BUS_BITS steps per operation,
// so latency is fixed regardless of op or operand values.
// BUS_BITS is expected to be even and at least 8.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int BUS_BITS = 64
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   localparam int CNT_BITS = $clog2(BUS_BITS + 1);

   // Datapath and control state. During a multiply {r_hi, r_lo} is the
   // running product with the multiplier shifting out of r_lo; during a
   // divide r_hi is the partial remainder and r_lo shifts the dividend
   // out while the quotient shifts in. r_opnd holds the multiplicand or
   // the divisor magnitude.
   state_e              r_state;
   op_e                 r_op;
   logic [BUS_BITS-1:0] r_hi;
   logic [BUS_BITS-1:0] r_lo;
   logic [BUS_BITS-1:0] r_opnd;
   logic [BUS_BITS-1:0] r_result;
   logic [CNT_BITS-1:0] r_cnt;
   logic                r_neg;
   logic                r_div_zero;

   logic                w_accept;
   logic                w_is_div;
   logic                w_is_sdiv;
   logic [BUS_BITS-1:0] w_abs_a;
   logic [BUS_BITS-1:0] w_abs_b;
   logic [BUS_BITS:0]   w_add;
   logic [BUS_BITS:0]   w_shifted;
   logic [BUS_BITS:0]   w_diff;
   logic [BUS_BITS-1:0] w_next_hi;
   logic [BUS_BITS-1:0] w_next_lo;
   logic [BUS_BITS-1:0] w_quot;
   logic [BUS_BITS-1:0] w_result;

   // A new request is taken only when not iterating and not flushing.
   assign w_accept  = bus.start && !bus.flush && (r_state != RUN);
   assign w_is_div  = bus.op[1];
   assign w_is_sdiv = (bus.op == OP_SDIV);

   // Operand magnitudes for a signed divide; pass-through otherwise.
   muldiv_sign_fix #(.BUS_BITS(BUS_BITS)) u_fix_a (
      .i_value  (bus.in1),
      .i_negate (w_is_sdiv && bus.in1[BUS_BITS-1]),
      .o_value  (w_abs_a)
   );

   muldiv_sign_fix #(.BUS_BITS(BUS_BITS)) u_fix_b (
      .i_value  (bus.in2),
      .i_negate (w_is_sdiv && bus.in2[BUS_BITS-1]),
      .o_value  (w_abs_b)
   );

   // One iteration step of the latched operation.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      w_next_hi = r_hi;
      w_next_lo = r_lo;
      w_add     = {1'b0, r_hi} + {1'b0, r_opnd};
      w_shifted = {r_hi, r_lo[BUS_BITS-1]};
      w_diff    = w_shifted - {1'b0, r_opnd};
      if (r_op[1]) begin
         // Restoring divide: keep the subtraction only if it did not borrow.
         if (!w_diff[BUS_BITS]) begin
            w_next_hi = w_diff[BUS_BITS-1:0];
            w_next_lo = {r_lo[BUS_BITS-2:0], 1'b1};
         end else begin
            w_next_hi = w_shifted[BUS_BITS-1:0];
            w_next_lo = {r_lo[BUS_BITS-2:0], 1'b0};
         end
      end else begin
         // Shift-add multiply: the carry out of the add re-enters at the top.
         if (r_lo[0]) begin
            {w_next_hi, w_next_lo} = {w_add, r_lo[BUS_BITS-1:1]};
         end else begin
            {w_next_hi, w_next_lo} = {1'b0, r_hi, r_lo[BUS_BITS-1:1]};
         end
      end
   end

   // Restore the quotient sign; r_neg is only ever set for a signed divide.
   muldiv_sign_fix #(.BUS_BITS(BUS_BITS)) u_fix_q (
      .i_value  (w_next_lo),
      .i_negate (r_neg),
      .o_value  (w_quot)
   );

   // Select the value to publish on the final step.
   always_comb begin
      case (r_op)
         OP_MUL:   w_result = w_next_lo;
         OP_UMULH: w_result = w_next_hi;
         default:  w_result = r_div_zero ? '0 : w_quot;
      endcase
   end

   // Sequencer and datapath registers: reset, then flush, then the FSM.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_state    <= IDLE;
         r_op       <= OP_MUL;
         r_hi       <= '0;
         r_lo       <= '0;
         r_opnd     <= '0;
         r_result   <= '0;
         r_cnt      <= '0;
         r_neg      <= 1'b0;
         r_div_zero <= 1'b0;
      end else if (bus.flush) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_state    <= RUN;
                  r_op       <= bus.op;
                  r_hi       <= '0;
                  r_lo       <= w_is_div ? w_abs_a : bus.in2;
                  r_opnd     <= w_is_div ? w_abs_b : bus.in1;
                  r_cnt      <= CNT_BITS'(BUS_BITS);
                  r_neg      <= w_is_sdiv &&
                                (bus.in1[BUS_BITS-1] ^ bus.in2[BUS_BITS-1]);
                  r_div_zero <= w_is_div && (bus.in2 == '0);
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_hi  <= w_next_hi;
               r_lo  <= w_next_lo;
               r_cnt <= r_cnt - CNT_BITS'(1);
               if (r_cnt == CNT_BITS'(1)) begin
                  r_state  <= DONE;
                  r_result <= w_result;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = (r_state == RUN);
   assign bus.done   = (r_state == DONE);
   assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at BUS_BITS=64. Cycle n is the interval
// after the (n-1)-th rising edge counted from the accepting edge; all
// sampling and driving happens 1 time unit after a rising edge.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic seen_busy;
   logic seen_done;

   muldiv_if #(.BUS_BITS(64)) bus ();

   muldiv_unit #(.BUS_BITS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; returns in cycle 1 of the operation.
   task automatic issue(input op_e op, input logic [63:0] a, input logic [63:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.in1   = a;
      bus.in2   = b;
      tick();
      bus.start = 1'b0;
   endtask

   // Full operation; returns in cycle 65 with done expected high.
   task automatic run_op(input string tag, input op_e op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
      issue(op, a, b);
      repeat (63) tick();
      check({tag, " c64 busy/done"}, {62'd0, bus.busy, bus.done}, 64'd2);
      tick();
      check({tag, " c65 busy/done"}, {62'd0, bus.busy, bus.done}, 64'd1);
      check({tag, " result"}, bus.result, exp);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = OP_MUL;
      bus.in1   = '0;
      bus.in2   = '0;
      tick();
      tick();
      check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
      check("reset result", bus.result, 64'd0);
      rst_n = 1'b1;
      tick();

      // MUL 7x6 with per-cycle busy/done profile.
      issue(OP_MUL, 64'd7, 64'd6);
      for (int c = 1; c <= 64; c++) begin
         check($sformatf("mul7x6 c%0d busy/done", c), {62'd0, bus.busy, bus.done}, 64'd2);
         tick();
      end
      check("mul7x6 c65 busy/done", {62'd0, bus.busy, bus.done}, 64'd1);
      check("mul7x6 result", bus.result, 64'd42);
      tick();
      check("mul7x6 c66 idle", {62'd0, bus.busy, bus.done}, 64'd0);
      check("mul7x6 result held", bus.result, 64'd42);

      // Back-to-back operations, each issued from DONE.
      run_op("umulh ffff*2", OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
      run_op("mul ffff*2", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("umulh ffff*ffff", OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("mul -3*5", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("sdiv -7/2", OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("sdiv 7/-2", OP_SDIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("sdiv -8/-2", OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4);
      run_op("udiv 100/0", OP_UDIV, 64'd100, 64'd0, 64'd0);
      run_op("sdiv -5/0", OP_SDIV, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0);
      run_op("sdiv min/-1", OP_SDIV, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
      run_op("udiv ffff/16", OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF);
      tick();
      check("post b2b idle", {62'd0, bus.busy, bus.done}, 64'd0);

      // Start during RUN is ignored.
      issue(OP_UDIV, 64'd100, 64'd7);
      repeat (9) tick();
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.in1   = 64'd3;
      bus.in2   = 64'd3;
      tick();
      bus.start = 1'b0;
      check("ignored start c11 busy", {63'd0, bus.busy}, 64'd1);
      repeat (53) tick();
      check("ignored start c64 busy/done", {62'd0, bus.busy, bus.done}, 64'd2);
      tick();
      check("ignored start c65 busy/done", {62'd0, bus.busy, bus.done}, 64'd1);
      check("udiv 100/7 result", bus.result, 64'd14);
      tick();

      // Flush mid-operation, with a simultaneous start that must lose.
      issue(OP_MUL, 64'd5, 64'd5);
      repeat (19) tick();
      bus.flush = 1'b1;
      bus.start = 1'b1;
      bus.in1   = 64'd9;
      bus.in2   = 64'd9;
      tick();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      check("flush c21 busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
      check("flush c21 result", bus.result, 64'd14);
      seen_busy = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 70; c++) begin
         tick();
         seen_busy = seen_busy | bus.busy;
         seen_done = seen_done | bus.done;
      end
      check("flush no busy after", {63'd0, seen_busy}, 64'd0);
      check("flush no done after", {63'd0, seen_done}, 64'd0);
      check("flush result kept", bus.result, 64'd14);

      // Reset mid-operation.
      issue(OP_UDIV, 64'd1000, 64'd10);
      repeat (29) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("reset c31 busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
      check("reset c31 result", bus.result, 64'd0);
      seen_busy = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 70; c++) begin
         tick();
         seen_busy = seen_busy | bus.busy;
         seen_done = seen_done | bus.done;
      end
      check("reset no busy after", {63'd0, seen_busy}, 64'd0);
      check("reset no done after", {63'd0, seen_done}, 64'd0);
      check("reset result stays 0", bus.result, 64'd0);
      run_op("mul 12x12 after reset", OP_MUL, 64'd12, 64'd12, 64'd144);
      tick();
      check("final idle", {62'd0, bus.busy, bus.done}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter BUS_BITS, default 64, operand/result width; SHALL be even and >= 8.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request pulse; operands and op are sampled when it is accepted.
REQ-005 op  input  2  operation: 00 MUL (low half), 01 UMULH (high half of unsigned product), 10 UDIV, 11 SDIV.
REQ-006 in1  input  BUS_BITS  operand A (multiplicand/dividend), driven by the operand-forwarding Mux4.
REQ-007 in2  input  BUS_BITS  operand B (multiplier/divisor), driven by the operand-forwarding Mux4.
REQ-008 flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 busy  output  1  high while an operation is iterating.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 result  output  BUS_BITS  registered result, held until the next accepted start.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-013 start SHALL be accepted in IDLE or DONE when flush=0; on acceptance in, op and an iteration counter of BUS_BITS SHALL be latched and the state SHALL go to RUN.
REQ-014 start while in RUN SHALL be ignored, with no effect on state, operands or result.
REQ-015 RUN SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, decrementing the counter; on the step where the counter reaches 0, the state SHALL go to DONE and result SHALL load.
REQ-016 Latency SHALL be fixed: done is high in the BUS_BITS+1-th cycle after the accepting edge, for every op and operand value.
REQ-017 From DONE without an accepted start, the state SHALL return to IDLE; an accepted start in DONE SHALL give back-to-back operation.
REQ-018 MUL SHALL return product bits [BUS_BITS-1:0], identical for signed and unsigned interpretation; UMULH SHALL return bits [2*BUS_BITS-1:BUS_BITS] of the unsigned product.
REQ-019 UDIV SHALL return the unsigned quotient; SDIV SHALL divide magnitudes and negate the quotient when operand signs differ (truncation toward zero).
REQ-020 A divisor of 0 SHALL give result 0 for UDIV and SDIV, with the same latency.
REQ-021 SDIV of the most negative value by -1 SHALL give the most negative value (wrap), with no flag.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, leave result unchanged, and suppress done; flush SHALL win over a simultaneous start.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state IDLE, busy=0, done=0, result=0 and counter=0, including mid-operation; no done SHALL follow a reset.
REQ-024 Reset SHALL take priority over flush and start in the same cycle.

Structure
REQ-025 A shared package muldiv_pkg SHALL hold the op encodings (OP_MUL, OP_UMULH, OP_UDIV, OP_SDIV) and the state enumeration.
REQ-026 Sign handling (absolute value on entry, conditional negate on exit) SHALL be one sub-module, muldiv_sign_fix, instantiated for the operands and for the result; datapath registers and the FSM SHALL stay in muldiv_unit.

Verification (BUS_BITS=64)
REQ-027 MUL 7 x 6, start at edge 0 -> busy=1 at cycles 1..64, done=1 at cycle 65 only, result=42.
REQ-028 UMULH 0xFFFF_FFFF_FFFF_FFFF x 2 -> result=1; MUL with the same operands -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-029 SDIV -7 / 2 -> result=-3; UDIV 100 / 0 -> result=0; SDIV 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000; all done at cycle 65.
REQ-030 UDIV 100/7 started; second start (op MUL, 3x3) at cycle 10 -> ignored, result=14 at cycle 65.
REQ-031 MUL 5x5 started; flush at cycle 20 -> IDLE at cycle 21, no done, result keeps previous value; start asserted together with flush is not accepted.
REQ-032 rst_n=0 at cycle 30 of a UDIV -> busy=0, done=0, result=0 from cycle 31; no done thereafter; a new start afterwards completes normally.
